// File: rtl/cpu_pkg.sv
// Core-wide widths and the write-back entry layout shared by the register file and its write-back path.
// Pure declarations: no latency, no flow control.
package cpu_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with a combinational head; push is ignored when full, pop when empty.
// Write-to-read latency 1 cycle; the caller owns backpressure through full/empty.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REG_ADDR_W + XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // The extra MSB tells a full ring (wrap bits differ) from an empty one.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline and buffered accelerator results onto the single rf write port; pipe wins, 1-cycle pipe / >=2-cycle acc latency.
// Accelerator is back-pressured by acc_ready when the buffer is full; long denial raises stall_req.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_wd,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [REG_ADDR_W-1:0] acc_rd,
  input  logic [XLEN-1:0]       acc_wd,
  input  logic                  acc_issue,
  input  logic [REG_ADDR_W-1:0] acc_issue_rd,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wd,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic                  stall_req
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          active;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  wb_entry_t     acc_in;
  wb_entry_t     head;
  logic [CW-1:0] starve_cnt;
  logic [NUM_REGS-1:0] pend_next;

  assign active    = pipe_we && (pipe_rd != '0);
  assign acc_ready = !full && !reset;
  assign push      = acc_valid && acc_ready;
  assign pop       = !empty && !active && !reset;
  assign acc_in    = '{rd: acc_rd, wd: acc_wd};

  wb_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(REG_ADDR_W + XLEN)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (acc_in),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  // Set beats clear so a re-issue racing the older result's retirement stays pending.
  always_comb begin
    pend_next = pend_mask;
    if (pop && head.rd != '0) pend_next[head.rd] = 1'b0;
    if (acc_issue && acc_issue_rd != '0) pend_next[acc_issue_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wd      <= '0;
      pend_mask  <= '0;
      stall_req  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rf_we <= 1'b0;
      if (active) begin
        rf_we <= 1'b1;
        rf_rd <= pipe_rd;
        rf_wd <= pipe_wd;
      end else if (pop) begin
        rf_we <= (head.rd != '0);
        rf_rd <= head.rd;
        rf_wd <= head.wd;
      end

      // Non-empty without a pop implies the pipe took the slot.
      if (pop || empty)           starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;

      if (pop)                      stall_req <= 1'b0;
      else if (starve_cnt == LIMIT) stall_req <= 1'b1;

      pend_mask <= pend_next;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based reference model.
// Model predicts acc_ready before each edge and rf/pend/stall after it.
module tb_wb_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        acc_valid;
  logic        acc_ready;
  logic [4:0]  acc_rd;
  logic [31:0] acc_wd;
  logic        acc_issue;
  logic [4:0]  acc_issue_rd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] pend_mask;
  logic        stall_req;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_rd(acc_rd), .acc_wd(acc_wd),
    .acc_issue(acc_issue), .acc_issue_rd(acc_issue_rd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .pend_mask(pend_mask), .stall_req(stall_req)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pend = '0;
  int          m_starve = 0;
  logic        m_stall = 1'b0;
  logic [71:0] exp_vec;
  logic        rdy_seen;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [71:0] pack(input logic rdy, input logic we, input logic [4:0] rd,
                                       input logic [31:0] wd, input logic [31:0] pm, input logic st);
    return {rdy, we, we ? rd : 5'd0, we ? wd : 32'd0, pm, st};
  endfunction

  function automatic logic [71:0] obs();
    return pack(rdy_seen, rf_we, rf_rd, rf_wd, pend_mask, stall_req);
  endfunction

  // Advances one clock: predicts from the current inputs, then samples 1 ns after the edge.
  task automatic cycle();
    logic        m_rdy, act, pop, e_we, was_empty;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    ent_t        e;
    int          old_starve;
    #1;
    rdy_seen = acc_ready;
    m_rdy = !reset && (q.size() < DEPTH);
    act = pipe_we && (pipe_rd != 5'd0);
    e_we = 1'b0; e_rd = '0; e_wd = '0;
    if (reset) begin
      q.delete();
      m_pend = '0; m_starve = 0; m_stall = 1'b0;
    end else begin
      was_empty = (q.size() == 0);
      pop = !was_empty && !act;
      old_starve = m_starve;
      if (act) begin
        e_we = 1'b1; e_rd = pipe_rd; e_wd = pipe_wd;
      end else if (pop) begin
        e = q.pop_front();
        e_we = (e.rd != 5'd0); e_rd = e.rd; e_wd = e.wd;
        if (e.rd != 5'd0) m_pend[e.rd] = 1'b0;
      end
      m_starve = (pop || was_empty) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
      if (pop) m_stall = 1'b0;
      else if (old_starve == LIMIT) m_stall = 1'b1;
      if (acc_issue && acc_issue_rd != 5'd0) m_pend[acc_issue_rd] = 1'b1;
      if (acc_valid && m_rdy) q.push_back('{acc_rd, acc_wd});
    end
    exp_vec = pack(m_rdy, e_we, e_rd, e_wd, m_pend, m_stall);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_wd = '0;
    acc_valid = 1'b0; acc_rd = '0; acc_wd = '0; acc_issue = 1'b0; acc_issue_rd = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (obs() !== exp_vec) begin errors++; $display("FAIL reset got %h exp %h", obs(), exp_vec); end
    end
    checks++;
    if ({rf_rd, rf_wd} !== 37'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {rf_rd, rf_wd}); end
    idle();
  endtask

  task automatic test_pipe();
    idle();
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hDEADBEEF;
    cycle();
    checks++;
    if (obs() !== exp_vec) begin errors++; $display("FAIL pipe got %h exp %h", obs(), exp_vec); end
    checks++;
    if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL pipe_direct got %h exp %h", {rf_we, rf_rd, rf_wd}, {1'b1, 5'd5, 32'hDEADBEEF});
    end
    pipe_rd = 5'd0;
    cycle();
    checks++;
    if (obs() !== exp_vec) begin errors++; $display("FAIL pipe_x0 got %h exp %h", obs(), exp_vec); end
    idle();
  endtask

  task automatic test_acc_latency();
    idle();
    acc_valid = 1'b1; acc_rd = 5'd7; acc_wd = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      cycle();
      idle();
      checks++;
      if (obs() !== exp_vec) begin errors++; $display("FAIL acc_lat%0d got %h exp %h", i, obs(), exp_vec); end
      if (i == 1) begin
        checks++;
        if ({rf_we, rf_rd, rf_wd} !== {1'b1, 5'd7, 32'h1234}) begin
          errors++; $display("FAIL acc_t2 got %h exp %h", {rf_we, rf_rd, rf_wd}, {1'b1, 5'd7, 32'h1234});
        end
      end
    end
  endtask

  task automatic test_starve();
    int sent = 0, first = -1, stall_at = -1;
    bit stop = 0;
    idle();
    for (int k = 0; k < 60; k++) begin
      pipe_we = !stop; pipe_rd = 5'd20; pipe_wd = $urandom;
      acc_valid = (sent < 5); acc_rd = 5'(10 + sent); acc_wd = 32'hA000 + 32'(sent);
      cycle();
      checks++;
      if (obs() !== exp_vec) begin errors++; $display("FAIL starve k%0d got %h exp %h", k, obs(), exp_vec); end
      if (acc_valid && rdy_seen) begin
        if (first < 0) first = k;
        sent++;
      end
      if (stall_req && stall_at < 0) begin stall_at = k; stop = 1; end
      if (stop && sent == 5 && q.size() == 0) break;
    end
    checks++;
    if (stall_at - first != LIMIT + 1) begin
      errors++; $display("FAIL stall_time got %0d exp %0d", stall_at - first, LIMIT + 1);
    end
    checks++;
    if (sent != 5 || q.size() != 0) begin
      errors++; $display("FAIL starve_drain got sent %0d left %0d exp 5 0", sent, q.size());
    end
    idle();
    cycle();
  endtask

  task automatic test_scoreboard();
    idle();
    acc_issue = 1'b1; acc_issue_rd = 5'd3;
    cycle();
    idle();
    checks++;
    if (pend_mask !== 32'h8) begin errors++; $display("FAIL pend_set got %h exp 00000008", pend_mask); end
    acc_valid = 1'b1; acc_rd = 5'd3; acc_wd = 32'h3333;
    cycle();
    idle();
    checks++;
    if (obs() !== exp_vec) begin errors++; $display("FAIL pend_acc got %h exp %h", obs(), exp_vec); end
    cycle();
    checks++;
    if ({rf_we, rf_rd, pend_mask[3]} !== {1'b1, 5'd3, 1'b0}) begin
      errors++; $display("FAIL pend_clear got %h exp %h", {rf_we, rf_rd, pend_mask[3]}, {1'b1, 5'd3, 1'b0});
    end
    acc_issue = 1'b1; acc_issue_rd = 5'd0;
    cycle();
    idle();
    checks++;
    if (obs() !== exp_vec) begin errors++; $display("FAIL pend_x0 got %h exp %h", obs(), exp_vec); end
  endtask

  task automatic test_set_wins();
    idle();
    acc_issue = 1'b1; acc_issue_rd = 5'd3;
    cycle();
    idle();
    acc_valid = 1'b1; acc_rd = 5'd3; acc_wd = 32'h5A5A;
    cycle();
    idle();
    acc_issue = 1'b1; acc_issue_rd = 5'd3;
    cycle();
    idle();
    checks++;
    if ({rf_we, rf_rd, pend_mask[3]} !== {1'b1, 5'd3, 1'b1}) begin
      errors++; $display("FAIL set_wins got %h exp %h", {rf_we, rf_rd, pend_mask[3]}, {1'b1, 5'd3, 1'b1});
    end
    checks++;
    if (obs() !== exp_vec) begin errors++; $display("FAIL set_wins_m got %h exp %h", obs(), exp_vec); end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1'b1; pipe_rd = 5'd21; pipe_wd = 32'(i);
      acc_valid = 1'b1; acc_rd = 5'(4 + i); acc_wd = 32'hB000 + 32'(i);
      cycle();
    end
    idle();
    reset = 1'b1; acc_valid = 1'b1; acc_rd = 5'd9;
    cycle();
    checks++;
    if (rdy_seen !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", rdy_seen); end
    idle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if ({rf_we, pend_mask} !== 33'd0) begin
        errors++; $display("FAIL rst_stale%0d got %h exp 0", i, {rf_we, pend_mask});
      end
      checks++;
      if (obs() !== exp_vec) begin errors++; $display("FAIL rst_mid%0d got %h exp %h", i, obs(), exp_vec); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      pipe_we = ($urandom_range(0, 99) < 45); pipe_rd = 5'($urandom); pipe_wd = $urandom;
      acc_valid = ($urandom_range(0, 99) < 60); acc_rd = 5'($urandom); acc_wd = $urandom;
      acc_issue = ($urandom_range(0, 99) < 30); acc_issue_rd = 5'($urandom);
      cycle();
      checks++;
      if (obs() !== exp_vec) begin errors++; $display("FAIL rand%0d got %h exp %h", i, obs(), exp_vec); end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_pipe();
    test_acc_latency();
    test_starve();
    test_scoreboard();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
